// File: rtl/fetch_pc_ctl_if.sv
// Fetch PC control bus: redirect requests, stall, accepted-instruction
// qualifiers flowing into the PC block, and the registered fetch PC out.
interface fetch_pc_ctl_if;
    logic        stall;
    logic        trap_en;
    logic [63:0] trap_pc;
    logic        bj_en;
    logic [63:0] bj_pc;
    logic        inst_valid;
    logic        inst_compressed;
    logic [63:0] pc;

    // Requester side (pipeline control / execute / commit)
    modport master (
        output stall,
        output trap_en,
        output trap_pc,
        output bj_en,
        output bj_pc,
        output inst_valid,
        output inst_compressed,
        input  pc
    );

    // PC block side
    modport slave (
        input  stall,
        input  trap_en,
        input  trap_pc,
        input  bj_en,
        input  bj_pc,
        input  inst_valid,
        input  inst_compressed,
        output pc
    );
endinterface

// File: rtl/fetch_pc_ctl.sv
// Fetch program-counter control: one 64-bit PC register, a strict-priority
// next-PC mux (reset > trap > branch/jump > stall > sequential advance) and
// the +2/+4 sequential adders. Redirect targets are halfword aligned on load.
module fetch_pc_ctl #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic           clk,
    input  logic           rst_n,
    fetch_pc_ctl_if.slave  bus
);

    logic [63:0] pc_reg;
    logic [63:0] pc_next;
    logic [63:0] pc_seq;

    // Sequential advance size chosen by instruction width; wraps modulo 2^64
    always_comb begin
        pc_seq = pc_reg + (bus.inst_compressed ? 64'd2 : 64'd4);
    end

    // Next-PC selection; redirects override stall and never add an increment
    always_comb begin
        pc_next = pc_reg;
        if (bus.trap_en) begin
            pc_next = {bus.trap_pc[63:1], 1'b0};
        end else if (bus.bj_en) begin
            pc_next = {bus.bj_pc[63:1], 1'b0};
        end else if (bus.stall) begin
            pc_next = pc_reg;
        end else if (bus.inst_valid) begin
            pc_next = pc_seq;
        end
    end

    // PC register; reset wins over every pending redirect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign bus.pc = pc_reg;

endmodule

// File: tb/tb_fetch_pc_ctl.sv
// Directed bench for fetch_pc_ctl: each task drives a short scenario and
// compares the registered PC against hand-computed values after every edge.
module tb_fetch_pc_ctl;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    fetch_pc_ctl_if bus ();

    fetch_pc_ctl #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, let one rising edge pass, sample 1 time unit later
    task automatic cycle(input logic r, input logic t, input logic [63:0] tpc,
                         input logic b, input logic [63:0] bpc, input logic s,
                         input logic iv, input logic ic);
        rst_n               = r;
        bus.trap_en         = t;
        bus.trap_pc         = tpc;
        bus.bj_en           = b;
        bus.bj_pc           = bpc;
        bus.stall           = s;
        bus.inst_valid      = iv;
        bus.inst_compressed = ic;
        @(posedge clk);
        #1;
        $display("[TB] rst_n=%b trap=%b/%h bj=%b/%h stall=%b valid=%b comp=%b -> pc=%h",
                 r, t, tpc, b, bpc, s, iv, ic, bus.pc);
    endtask

    task automatic test_reset();
        logic [63:0] exp;
        exp = RST_PC;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b1, 64'h1234, 1'b1, 64'h5678, 1'b0, 1'b1, 1'b0);
            n_tests++;
            if (bus.pc !== exp) begin
                n_fail++;
                $display("FAIL reset[%0d]: pc=%h expected %h", i, bus.pc, exp);
            end
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
            n_tests++;
            if (bus.pc !== exp) begin
                n_fail++;
                $display("FAIL idle_hold[%0d]: pc=%h expected %h", i, bus.pc, exp);
            end
        end
    endtask

    task automatic test_sequential();
        logic        iv_v  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        ic_v  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [63:0] exp_v [6] = '{64'h8000_0004, 64'h8000_0008, 64'h8000_000A,
                                   64'h8000_000C, 64'h8000_000C, 64'h8000_000C};
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, iv_v[i], ic_v[i]);
            n_tests++;
            if (bus.pc !== exp_v[i]) begin
                n_fail++;
                $display("FAIL seq[%0d]: pc=%h expected %h", i, bus.pc, exp_v[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [63:0] exp;
        cycle(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        exp = 64'h8000_0010;
        n_tests++;
        if (bus.pc !== exp) begin
            n_fail++;
            $display("FAIL stall_setup: pc=%h expected %h", bus.pc, exp);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
            n_tests++;
            if (bus.pc !== exp) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: pc=%h expected %h", i, bus.pc, exp);
            end
        end
        cycle(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        exp = 64'h8000_0014;
        n_tests++;
        if (bus.pc !== exp) begin
            n_fail++;
            $display("FAIL stall_release: pc=%h expected %h", bus.pc, exp);
        end
    endtask

    task automatic test_redirect();
        logic        t_v   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [63:0] tpc_v [6] = '{64'h0, 64'h1000, 64'h0, 64'h3003, 64'h0, 64'h0};
        logic        b_v   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [63:0] bpc_v [6] = '{64'h8000_0020, 64'h2000, 64'h2001, 64'h0, 64'h4000, 64'h0};
        logic        s_v   [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        iv_v  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        ic_v  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [63:0] exp_v [6] = '{64'h8000_0020, 64'h1000, 64'h2000,
                                   64'h3002, 64'h4000, 64'h4002};
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, t_v[i], tpc_v[i], b_v[i], bpc_v[i], s_v[i], iv_v[i], ic_v[i]);
            n_tests++;
            if (bus.pc !== exp_v[i]) begin
                n_fail++;
                $display("FAIL redirect[%0d]: pc=%h expected %h", i, bus.pc, exp_v[i]);
            end
        end
    endtask

    task automatic test_wraparound();
        logic        b_v   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [63:0] bpc_v [4] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0};
        logic        ic_v  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic        iv_v  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [63:0] exp_v [4] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 64'h0, b_v[i], bpc_v[i], 1'b0, iv_v[i], ic_v[i]);
            n_tests++;
            if (bus.pc !== exp_v[i]) begin
                n_fail++;
                $display("FAIL wrap[%0d]: pc=%h expected %h", i, bus.pc, exp_v[i]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic        r_v   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic        b_v   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [63:0] exp_v [4] = '{64'h4, 64'h8, 64'h8000_0000, 64'h8000_0004};
        for (int i = 0; i < 4; i++) begin
            cycle(r_v[i], 1'b0, 64'h0, b_v[i], 64'h5000, 1'b0, 1'b1, 1'b0);
            n_tests++;
            if (bus.pc !== exp_v[i]) begin
                n_fail++;
                $display("FAIL reset_mid[%0d]: pc=%h expected %h", i, bus.pc, exp_v[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        t_v   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [63:0] tpc_v [4] = '{64'hA000, 64'h0, 64'hC001, 64'h0};
        logic        b_v   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [63:0] bpc_v [4] = '{64'h0, 64'hB000, 64'hD000, 64'h0};
        logic [63:0] exp_v [4] = '{64'hA000, 64'hB000, 64'hC000, 64'hC004};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, t_v[i], tpc_v[i], b_v[i], bpc_v[i], 1'b0, 1'b1, 1'b0);
            n_tests++;
            if (bus.pc !== exp_v[i]) begin
                n_fail++;
                $display("FAIL b2b[%0d]: pc=%h expected %h", i, bus.pc, exp_v[i]);
            end
        end
    endtask

    initial begin
        n_tests             = 0;
        n_fail              = 0;
        rst_n               = 1'b0;
        bus.stall           = 1'b0;
        bus.trap_en         = 1'b0;
        bus.trap_pc         = 64'h0;
        bus.bj_en           = 1'b0;
        bus.bj_pc           = 64'h0;
        bus.inst_valid      = 1'b0;
        bus.inst_compressed = 1'b0;
        #2;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_wraparound();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
